dmem_req_ctrl: RTL and testbench

Requester-side controller for the dual-port data memory in the two-core processor. It takes the MEM-stage load/store requests of core A and core B and drives the A and B ports of `dmem`. It serializes same-word write conflicts with round-robin priority and stalls the losing core. It also implements LL/SC reservations so the cores can run atomic read-modify-write sequences.

---
 rtl/dmem_req_ctrl.sv | 102 ++++++++++
 tb/tb_dmem_req_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_req_ctrl.sv
// Requester-side controller for the shared dual-port data memory: arbitrates
// same-word write conflicts round-robin and tracks per-core LL/SC reservations.
module dmem_req_ctrl #(
   parameter int WIDX = 30
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ReqA,
   input  logic        WeA,
   input  logic        LlA,
   input  logic        ScA,
   input  logic [31:0] AddrA,
   input  logic [31:0] WdataA,
   output logic [31:0] RdataA,
   output logic        StallA,
   output logic        MemWeA,
   output logic [31:0] MemAddrA,
   output logic [31:0] MemWdA,
   input  logic [31:0] MemRdA,
   input  logic        ReqB,
   input  logic        WeB,
   input  logic        LlB,
   input  logic        ScB,
   input  logic [31:0] AddrB,
   input  logic [31:0] WdataB,
   output logic [31:0] RdataB,
   output logic        StallB,
   output logic        MemWeB,
   output logic [31:0] MemAddrB,
   output logic [31:0] MemWdB,
   input  logic [31:0] MemRdB
);

   logic            pri;
   logic            link_v_a, link_v_b;
   logic [WIDX-1:0] link_idx_a, link_idx_b;

   logic [WIDX-1:0] widx_a, widx_b;
   logic            ew_a, ew_b, conflict;
   logic            we_a, we_b;
   logic            ll_a, ll_b, sc_grant_a, sc_grant_b;
   logic            clr_a, clr_b;

   assign widx_a = AddrA[31 -: WIDX];
   assign widx_b = AddrB[31 -: WIDX];

   // An SC only becomes a real write while its own reservation still covers the word.
   assign ew_a = ReqA & (WeA | (ScA & link_v_a & (link_idx_a == widx_a)));
   assign ew_b = ReqB & (WeB | (ScB & link_v_b & (link_idx_b == widx_b)));

   assign conflict = ew_a & ew_b & (widx_a == widx_b);

   assign StallA = RST & conflict & pri;
   assign StallB = RST & conflict & ~pri;
   assign we_a   = RST & ew_a & ~StallA;
   assign we_b   = RST & ew_b & ~StallB;

   assign MemWeA   = we_a;
   assign MemWeB   = we_b;
   assign MemAddrA = AddrA;
   assign MemAddrB = AddrB;
   assign MemWdA   = WdataA;
   assign MemWdB   = WdataB;

   assign RdataA = ScA ? {31'b0, we_a} : MemRdA;
   assign RdataB = ScB ? {31'b0, we_b} : MemRdB;

   assign ll_a       = ReqA & LlA;
   assign ll_b       = ReqB & LlB;
   assign sc_grant_a = ReqA & ScA & ~StallA;
   assign sc_grant_b = ReqB & ScB & ~StallB;

   // A same-cycle LL is compared against the word it is linking, not the stale link.
   assign clr_a = sc_grant_a | (we_b & (ll_a ? (widx_b == widx_a) : (widx_b == link_idx_a)));
   assign clr_b = sc_grant_b | (we_a & (ll_b ? (widx_a == widx_b) : (widx_a == link_idx_b)));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pri        <= 1'b0;
         link_v_a   <= 1'b0;
         link_v_b   <= 1'b0;
         link_idx_a <= '0;
         link_idx_b <= '0;
      end else begin
         if (conflict)
            pri <= ~pri;
         if (ll_a)
            link_idx_a <= widx_a;
         if (ll_b)
            link_idx_b <= widx_b;
         if (clr_a)
            link_v_a <= 1'b0;
         else if (ll_a)
            link_v_a <= 1'b1;
         if (clr_b)
            link_v_b <= 1'b0;
         else if (ll_b)
            link_v_b <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl with a behavioural dual-port memory and a
// scoreboard queue of expected outputs compared at the falling clock edge.
module tb_dmem_req_ctrl;

   localparam int IDLE = 0;
   localparam int LD   = 1;
   localparam int ST   = 2;
   localparam int LL   = 3;
   localparam int SC   = 4;

   localparam int C_STALL_A = 0;
   localparam int C_STALL_B = 1;
   localparam int C_WE_A    = 2;
   localparam int C_WE_B    = 3;
   localparam int C_RD_A    = 4;
   localparam int C_RD_B    = 5;
   localparam int C_MEM     = 6;

   typedef struct {
      int          code;
      logic [31:0] addr;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ReqA, WeA, LlA, ScA, ReqB, WeB, LlB, ScB;
   logic [31:0] AddrA, WdataA, AddrB, WdataB;
   logic [31:0] RdataA, RdataB, MemAddrA, MemAddrB, MemWdA, MemWdB, MemRdA, MemRdB;
   logic        StallA, StallB, MemWeA, MemWeB;

   logic [31:0] mem [0:255] = '{default: 32'h0};

   always #5 CLK = ~CLK;

   assign MemRdA = mem[MemAddrA[9:2]];
   assign MemRdB = mem[MemAddrB[9:2]];

   always @(posedge CLK) begin
      if (MemWeA) mem[MemAddrA[9:2]] <= MemWdA;
      if (MemWeB) mem[MemAddrB[9:2]] <= MemWdB;
   end

   dmem_req_ctrl dut (
      .CLK(CLK), .RST(RST),
      .ReqA(ReqA), .WeA(WeA), .LlA(LlA), .ScA(ScA), .AddrA(AddrA), .WdataA(WdataA),
      .RdataA(RdataA), .StallA(StallA), .MemWeA(MemWeA), .MemAddrA(MemAddrA),
      .MemWdA(MemWdA), .MemRdA(MemRdA),
      .ReqB(ReqB), .WeB(WeB), .LlB(LlB), .ScB(ScB), .AddrB(AddrB), .WdataB(WdataB),
      .RdataB(RdataB), .StallB(StallB), .MemWeB(MemWeB), .MemAddrB(MemAddrB),
      .MemWdB(MemWdB), .MemRdB(MemRdB)
   );

   task automatic applyStimulus(input int op_a, input logic [31:0] addr_a, input logic [31:0] wd_a,
                                input int op_b, input logic [31:0] addr_b, input logic [31:0] wd_b);
      ReqA = (op_a != IDLE); WeA = (op_a == ST); LlA = (op_a == LL); ScA = (op_a == SC);
      AddrA = addr_a; WdataA = wd_a;
      ReqB = (op_b != IDLE); WeB = (op_b == ST); LlB = (op_b == LL); ScB = (op_b == SC);
      AddrB = addr_b; WdataB = wd_b;
   endtask

   task automatic expect_out(input int code, input logic [31:0] addr, input logic [31:0] exp,
                             input string tag);
      exp_t e;
      e.code = code; e.addr = addr; e.exp = exp; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input bit wait_neg, input bit advance);
      exp_t        e;
      logic [31:0] obs;
      if (wait_neg) @(negedge CLK);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.code)
            C_STALL_A: obs = {31'b0, StallA};
            C_STALL_B: obs = {31'b0, StallB};
            C_WE_A:    obs = {31'b0, MemWeA};
            C_WE_B:    obs = {31'b0, MemWeB};
            C_RD_A:    obs = RdataA;
            C_RD_B:    obs = RdataB;
            default:   obs = mem[e.addr[9:2]];
         endcase
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
         end
      end
      if (advance) begin
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      RST = 1'b0;
      applyStimulus(ST, 32'h10, 32'h1, ST, 32'h10, 32'h2);
      expect_out(C_STALL_A, 0, 0, "rst_stallA");
      expect_out(C_STALL_B, 0, 0, "rst_stallB");
      expect_out(C_WE_A, 0, 0, "rst_weA");
      expect_out(C_WE_B, 0, 0, "rst_weB");
      checkOutput(1, 1);
      RST = 1'b1;
      applyStimulus(IDLE, 0, 0, IDLE, 0, 0);
      expect_out(C_MEM, 32'h10, 32'h0, "rst_no_write");
      checkOutput(1, 1);

      // basic access
      applyStimulus(ST, 32'h10, 32'h11, ST, 32'h20, 32'h22);
      expect_out(C_WE_A, 0, 1, "basic_weA");
      expect_out(C_WE_B, 0, 1, "basic_weB");
      expect_out(C_STALL_A, 0, 0, "basic_stallA");
      expect_out(C_STALL_B, 0, 0, "basic_stallB");
      checkOutput(1, 1);
      applyStimulus(LD, 32'h20, 0, LD, 32'h11, 0);
      expect_out(C_RD_A, 0, 32'h22, "basic_ldA");
      expect_out(C_RD_B, 0, 32'h11, "basic_ldB_ignore_low_bits");
      checkOutput(1, 1);

      // write-write conflict, A wins first
      applyStimulus(ST, 32'h40, 32'hAA, ST, 32'h40, 32'hBB);
      expect_out(C_STALL_A, 0, 0, "ww1_stallA");
      expect_out(C_STALL_B, 0, 1, "ww1_stallB");
      expect_out(C_WE_A, 0, 1, "ww1_weA");
      expect_out(C_WE_B, 0, 0, "ww1_weB");
      checkOutput(1, 1);
      applyStimulus(IDLE, 0, 0, ST, 32'h40, 32'hBB);
      expect_out(C_WE_B, 0, 1, "ww2_weB");
      expect_out(C_STALL_B, 0, 0, "ww2_stallB");
      expect_out(C_MEM, 32'h40, 32'hAA, "ww2_word_after_A");
      checkOutput(1, 1);
      applyStimulus(ST, 32'h44, 32'h1, ST, 32'h44, 32'h2);
      expect_out(C_MEM, 32'h40, 32'hBB, "ww3_word_after_B");
      expect_out(C_STALL_A, 0, 1, "ww3_stallA");
      expect_out(C_STALL_B, 0, 0, "ww3_stallB");
      expect_out(C_WE_B, 0, 1, "ww3_weB");
      checkOutput(1, 1);
      applyStimulus(ST, 32'h44, 32'h1, IDLE, 0, 0);
      expect_out(C_WE_A, 0, 1, "ww4_weA");
      expect_out(C_STALL_A, 0, 0, "ww4_stallA");
      checkOutput(1, 1);

      // LL/SC success, then second SC fails
      applyStimulus(LL, 32'h80, 0, IDLE, 0, 0);
      expect_out(C_MEM, 32'h44, 32'h1, "ww5_word");
      expect_out(C_RD_A, 0, 32'h0, "ll1_rdata");
      checkOutput(1, 1);
      applyStimulus(SC, 32'h80, 32'h5, IDLE, 0, 0);
      expect_out(C_RD_A, 0, 1, "sc1_result");
      expect_out(C_WE_A, 0, 1, "sc1_weA");
      checkOutput(1, 1);
      applyStimulus(SC, 32'h80, 32'h7, IDLE, 0, 0);
      expect_out(C_RD_A, 0, 0, "sc2_result");
      expect_out(C_WE_A, 0, 0, "sc2_weA");
      expect_out(C_MEM, 32'h80, 32'h5, "sc1_word");
      checkOutput(1, 1);

      // LL/SC broken by the other core
      applyStimulus(LL, 32'h80, 0, IDLE, 0, 0);
      expect_out(C_MEM, 32'h80, 32'h5, "sc2_no_write");
      expect_out(C_RD_A, 0, 32'h5, "ll2_rdata");
      checkOutput(1, 1);
      applyStimulus(IDLE, 0, 0, ST, 32'h80, 32'h9);
      expect_out(C_WE_B, 0, 1, "brk_weB");
      checkOutput(1, 1);
      applyStimulus(SC, 32'h80, 32'h5, IDLE, 0, 0);
      expect_out(C_RD_A, 0, 0, "brk_sc_result");
      expect_out(C_WE_A, 0, 0, "brk_sc_weA");
      checkOutput(1, 1);
      applyStimulus(IDLE, 0, 0, IDLE, 0, 0);
      expect_out(C_MEM, 32'h80, 32'h9, "brk_word");
      checkOutput(1, 1);

      // simultaneous SC, Pri = 0
      applyStimulus(LL, 32'hC0, 0, LL, 32'hC0, 0);
      checkOutput(1, 1);
      applyStimulus(SC, 32'hC0, 32'h3, SC, 32'hC0, 32'h4);
      expect_out(C_RD_A, 0, 1, "dsc_resultA");
      expect_out(C_WE_A, 0, 1, "dsc_weA");
      expect_out(C_STALL_B, 0, 1, "dsc_stallB");
      expect_out(C_RD_B, 0, 0, "dsc_resultB_stalled");
      expect_out(C_WE_B, 0, 0, "dsc_weB");
      checkOutput(1, 1);
      applyStimulus(IDLE, 0, 0, SC, 32'hC0, 32'h4);
      expect_out(C_STALL_B, 0, 0, "dsc_retry_stallB");
      expect_out(C_RD_B, 0, 0, "dsc_retry_resultB");
      expect_out(C_WE_B, 0, 0, "dsc_retry_weB");
      expect_out(C_MEM, 32'hC0, 32'h3, "dsc_word");
      checkOutput(1, 1);

      // Pri is now 1: B wins, then reset lands during B's stall
      applyStimulus(IDLE, 0, 0, LL, 32'hF0, 0);
      checkOutput(1, 1);
      applyStimulus(ST, 32'hE0, 32'h1, ST, 32'hE0, 32'h2);
      expect_out(C_STALL_A, 0, 1, "pri1_stallA");
      expect_out(C_WE_B, 0, 1, "pri1_weB");
      checkOutput(1, 1);
      applyStimulus(ST, 32'hE0, 32'h1, IDLE, 0, 0);
      expect_out(C_WE_A, 0, 1, "pri1_retry_weA");
      checkOutput(1, 1);
      applyStimulus(ST, 32'hE4, 32'h5, ST, 32'hE4, 32'h6);
      expect_out(C_STALL_B, 0, 1, "prerst_stallB");
      expect_out(C_WE_A, 0, 1, "prerst_weA");
      checkOutput(1, 0);
      #2;
      RST = 1'b0;
      #1;
      expect_out(C_STALL_B, 0, 0, "midrst_stallB");
      expect_out(C_WE_A, 0, 0, "midrst_weA");
      expect_out(C_WE_B, 0, 0, "midrst_weB");
      checkOutput(0, 1);
      RST = 1'b1;
      applyStimulus(IDLE, 0, 0, SC, 32'hF0, 32'h6);
      expect_out(C_MEM, 32'hE4, 32'h0, "midrst_no_write");
      expect_out(C_RD_B, 0, 0, "midrst_link_lost");
      expect_out(C_WE_B, 0, 0, "midrst_link_lost_we");
      checkOutput(1, 1);
      applyStimulus(ST, 32'hE8, 32'h1, ST, 32'hE8, 32'h2);
      expect_out(C_STALL_B, 0, 1, "postrst_pri0_stallB");
      checkOutput(1, 1);
      applyStimulus(IDLE, 0, 0, ST, 32'hE8, 32'h2);
      expect_out(C_WE_B, 0, 1, "postrst_retry_weB");
      checkOutput(1, 1);

      // LL racing a same-word store from the other core
      applyStimulus(LL, 32'h100, 0, ST, 32'h100, 32'h77);
      expect_out(C_RD_A, 0, 32'h0, "llst_pre_write_read");
      expect_out(C_WE_B, 0, 1, "llst_weB");
      checkOutput(1, 1);
      applyStimulus(SC, 32'h100, 32'h8, IDLE, 0, 0);
      expect_out(C_RD_A, 0, 0, "llst_sc_fails");
      expect_out(C_WE_A, 0, 0, "llst_sc_weA");
      checkOutput(1, 1);
      applyStimulus(LL, 32'h104, 0, IDLE, 0, 0);
      expect_out(C_MEM, 32'h100, 32'h77, "llst_word");
      checkOutput(1, 1);

      // own plain store keeps own link
      applyStimulus(ST, 32'h104, 32'h1, IDLE, 0, 0);
      checkOutput(1, 1);
      applyStimulus(SC, 32'h104, 32'h2, IDLE, 0, 0);
      expect_out(C_RD_A, 0, 1, "own_store_keeps_link");
      checkOutput(1, 1);
      applyStimulus(IDLE, 0, 0, IDLE, 0, 0);
      expect_out(C_MEM, 32'h104, 32'h2, "own_store_sc_word");
      checkOutput(1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
